router_reg_pq: RTL and testbench
================================

Name: router_reg_pq

Overview:
- Parametrised packet register stage for the 1xN router. Sits between the source interface and the per-port output FIFOs.
- Runs its own two-state packet FSM, replacing the external ld/laf/lfd/full state strobes.
- Buffers bytes in a HOLD_DEPTH-deep output queue while the FIFO is full, and back-pressures the source with busy.
- Computes parity in XOR or additive-checksum mode, checks the header length field, and keeps a saturating error counter.

Parameters:
- DATA_W, 8: byte width of data_in/dout.
- ADDR_W, 2: header destination field width, header[ADDR_W-1:0]; length field is header[DATA_W-1:ADDR_W].
- HOLD_DEPTH, 2: output queue depth, >=1.
- PARITY_MODE, 0: 0 = XOR of all bytes; 1 = two's-complement sum mod 2^DATA_W.
- CNT_W, 8: err_count width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- pkt_valid  in  1  source packet valid (header/payload)
- data_in  in  DATA_W  source byte
- fifo_full  in  1  selected output FIFO full
- pkt_abort  in  1  synchronous packet abort/flush
- busy  out  1  source must hold pkt_valid/data_in stable while 1
- dout  out  DATA_W  byte to FIFO (queue head)
- dout_wr  out  1  dout valid for FIFO write
- dest  out  ADDR_W  registered header destination
- dest_valid  out  1  one-cycle pulse on header accept
- parity_done  out  1  parity byte received
- err  out  1  parity mismatch
- len_err  out  1  payload count != header length
- err_count  out  CNT_W  saturating count of packets with err or len_err

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE, queue empty. All outputs 0, including dest and err_count. Parity accumulator and payload counter are 0.
- busy is combinational: busy = (queue count == HOLD_DEPTH).
- No byte is accepted while busy=1, even if a pop happens in the same cycle.
- Queue pop: when dout_wr=1 and fifo_full=0, the head leaves. dout_wr = queue non-empty.
- Push and pop in the same cycle leave count unchanged. Order is strictly FIFO.
- A byte pushed at edge T appears on dout/dout_wr at T+1 when the queue was empty.
- State IDLE, pkt_valid=1, busy=0: header accepted.
  - Push header; latch dest and length field.
  - Accumulator <= header; payload counter <= 0.
  - Clear parity_done, err, len_err. Pulse dest_valid next cycle. Go to PAYLOAD.
- State IDLE, pkt_valid=0: idle, no push.
- State PAYLOAD, pkt_valid=1, busy=0: payload accepted.
  - Push byte; accumulator updated per PARITY_MODE.
  - Payload counter increments, saturating at 2^(DATA_W-ADDR_W)-1.
- State PAYLOAD, pkt_valid=0, busy=0: parity byte accepted.
  - Push it (parity byte is written to the FIFO).
  - parity_done <= 1; err <= (data_in != accumulator); len_err <= (counter != length field).
  - If err or len_err, err_count increments, saturating at all-ones. Go to IDLE.
- parity_done, err and len_err hold their values until the next header accept, pkt_abort, or reset.
- The header accept clears the flags in the same edge.
- busy=1 in any state: FSM, accumulator and counter hold. Source data is not sampled.
- pkt_abort=1 (below reset in priority):
  - Queue emptied, state IDLE, accumulator/counter/parity_done/err/len_err cleared.
  - Any byte offered that cycle is discarded. dest and err_count retained.
  - dout_wr=0 from the next cycle.
- Zero-payload packets (header then immediate parity byte) are legal. Parity compares against the header alone.
- RTL target 150-250 lines; no combinational path from fifo_full to busy.

Test Plan:
- Common setup unless stated: DATA_W=8, ADDR_W=2, HOLD_DEPTH=2, XOR mode, fifo_full=0.
- Clean packet: header 0x0D (dest 1, length 3), payloads 0x11,0x22,0x33, parity 0x0D.
  - dout 0x0D,0x11,0x22,0x33,0x0D on consecutive cycles; dest_valid pulse with dest=1.
  - parity_done=1, err=0, len_err=0, err_count=0.
- Same packet with parity byte 0x0E:
  - err=1 alongside parity_done; err_count=1; flags cleared on next header accept.
- fifo_full held high for 4 cycles after the first payload:
  - queue fills to 2 and busy=1; source holds; no byte lost or duplicated.
  - dout sequence is identical to the clean-packet case after release.
- Header 0x0D followed by only 2 payloads (0x11,0x22), parity 0x3E:
  - err=0, len_err=1, err_count increments.
- PARITY_MODE=1, bytes from the clean packet with parity 0x73:
  - err=0. Parity 0x0D must give err=1.
- pkt_abort after the second payload with fifo_full=1 (queue non-empty):
  - next cycle dout_wr=0, busy=0, parity_done=0, err_count unchanged.
  - a following clean packet passes correctly.

Source files
------------

// File: rtl/router_reg_pq.sv
// Router packet register stage: header/payload/parity FSM with a small hold queue.
// Computes XOR or additive parity, checks the header length and counts bad packets.
module router_reg_pq #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int HOLD_DEPTH  = 2,
    parameter int PARITY_MODE = 0,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              pkt_abort,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_wr,
    output logic [ADDR_W-1:0] dest,
    output logic              dest_valid,
    output logic              parity_done,
    output logic              err,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CW    = $clog2(HOLD_DEPTH + 1);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [HOLD_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [LEN_W-1:0]  pay_cnt, len_q;
    logic              hdr_acc, pay_acc, par_acc;
    logic              push, pop;
    logic              err_nxt, len_nxt;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(HOLD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // busy depends only on the registered occupancy, never on fifo_full
    assign busy    = (count == CW'(HOLD_DEPTH));
    assign dout_wr = (count != '0);
    assign dout    = dout_wr ? mem[rd_ptr] : '0;
    assign pop     = dout_wr && !fifo_full;
    assign push    = hdr_acc || pay_acc || par_acc;

    assign acc_nxt = (PARITY_MODE != 0) ? acc + data_in : acc ^ data_in;
    assign err_nxt = (data_in != acc);
    assign len_nxt = (pay_cnt != len_q);

    always_comb begin
        state_nxt = state;
        hdr_acc   = 1'b0;
        pay_acc   = 1'b0;
        par_acc   = 1'b0;
        if (pkt_abort) begin
            state_nxt = IDLE;
        end else if (!busy) begin
            unique case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        hdr_acc   = 1'b1;
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pkt_valid) begin
                        pay_acc = 1'b1;
                    end else begin
                        par_acc   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            acc         <= '0;
            pay_cnt     <= '0;
            len_q       <= '0;
            dest        <= '0;
            dest_valid  <= 1'b0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            state      <= state_nxt;
            dest_valid <= hdr_acc;
            if (pkt_abort) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                acc         <= '0;
                pay_cnt     <= '0;
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
            end else begin
                if (push) wr_ptr <= next_ptr(wr_ptr);
                if (pop) rd_ptr <= next_ptr(rd_ptr);
                if (push && !pop) count <= count + CW'(1);
                else if (!push && pop) count <= count - CW'(1);
                if (hdr_acc) begin
                    dest        <= data_in[ADDR_W-1:0];
                    len_q       <= data_in[DATA_W-1:ADDR_W];
                    acc         <= data_in;
                    pay_cnt     <= '0;
                    parity_done <= 1'b0;
                    err         <= 1'b0;
                    len_err     <= 1'b0;
                end
                if (pay_acc) begin
                    acc <= acc_nxt;
                    if (pay_cnt != '1) pay_cnt <= pay_cnt + LEN_W'(1);
                end
                if (par_acc) begin
                    parity_done <= 1'b1;
                    err         <= err_nxt;
                    len_err     <= len_nxt;
                    if ((err_nxt || len_nxt) && (err_count != '1))
                        err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_reg_pq.sv
// Bench for router_reg_pq: table vectors, directed corners and random packets.
// XOR and additive parity instances share the same stimulus.
module tb_router_reg_pq;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       fifo_full = 1'b0;
    logic       pkt_abort = 1'b0;

    logic       busy, dout_wr, dest_valid, parity_done, err, len_err;
    logic [7:0] dout, err_count;
    logic [1:0] dest;
    logic       busy1, dout_wr1, dest_valid1, parity_done1, err1, len_err1;
    logic [7:0] dout1, err_count1;
    logic [1:0] dest1;

    router_reg_pq dut0 (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .fifo_full(fifo_full), .pkt_abort(pkt_abort),
        .busy(busy), .dout(dout), .dout_wr(dout_wr), .dest(dest),
        .dest_valid(dest_valid), .parity_done(parity_done), .err(err),
        .len_err(len_err), .err_count(err_count)
    );

    router_reg_pq #(.PARITY_MODE(1)) dut1 (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid),
        .data_in(data_in), .fifo_full(fifo_full), .pkt_abort(pkt_abort),
        .busy(busy1), .dout(dout1), .dout_wr(dout_wr1), .dest(dest1),
        .dest_valid(dest_valid1), .parity_done(parity_done1), .err(err1),
        .len_err(len_err1), .err_count(err_count1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int ff_mode = 0;
    int c0 = 0;
    int c1 = 0;
    bit saw_busy = 0;
    logic [7:0] sb[$];
    logic [7:0] pl[80];

    typedef struct {
        logic [7:0] hdr;
        int         n;
        logic [7:0] p0, p1, p2;
        logic [7:0] par;
        bit         e0, le, e1, stall;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // fifo_full changes 2ns after the edge so it is stable at the negedge
    always @(posedge clk) begin
        #2;
        case (ff_mode)
            0:       fifo_full = 1'b0;
            1:       fifo_full = ($urandom_range(0, 2) == 0);
            default: fifo_full = 1'b1;
        endcase
    end

    // scoreboard: every byte leaving the queue must be the oldest accepted one
    always @(negedge clk) begin
        if (resetn && busy) saw_busy = 1;
        if (resetn && !pkt_abort && dout_wr && !fifo_full) begin
            if (sb.size() == 0) begin
                chk("dout_unexpected", {24'h0, dout}, 32'hFFFF);
            end else begin
                chk("dout_order", {24'h0, dout}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic v, input logic [7:0] d);
        int k;
        pkt_valid = v;
        data_in = d;
        k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("busy_timeout", 32'd1, 32'd0);
        sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n,
                            input logic [7:0] par, input bit e0,
                            input bit le, input bit e1, input bit stall);
        send_byte(1'b1, hdr);
        chk("dest_valid", {31'h0, dest_valid}, 32'd1);
        chk("dest", {30'h0, dest}, {30'h0, hdr[1:0]});
        chk("flags_clr", {29'h0, parity_done, err, len_err}, 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(1'b1, pl[i]);
            if (i == 0) begin
                chk("dest_valid_pulse", {31'h0, dest_valid}, 32'd0);
                if (stall) begin
                    saw_busy = 0;
                    ff_mode = 2;
                    fork
                        begin
                            repeat (4) @(posedge clk);
                            ff_mode = 0;
                        end
                    join_none
                end
            end
        end
        send_byte(1'b0, par);
        pkt_valid = 1'b0;
        if (e0 || le) c0 = (c0 < 255) ? c0 + 1 : 255;
        if (e1 || le) c1 = (c1 < 255) ? c1 + 1 : 255;
        chk("parity_done", {31'h0, parity_done}, 32'd1);
        chk("err", {31'h0, err}, {31'h0, e0});
        chk("len_err", {31'h0, len_err}, {31'h0, le});
        chk("err_count", {24'h0, err_count}, c0);
        chk("parity_done_sum", {31'h0, parity_done1}, 32'd1);
        chk("err_sum", {31'h0, err1}, {31'h0, e1});
        chk("len_err_sum", {31'h0, len_err1}, {31'h0, le});
        chk("err_count_sum", {24'h0, err_count1}, c1);
        if (stall) chk("saw_busy", {31'h0, saw_busy}, 32'd1);
    endtask

    task automatic set_vec(input int i, input logic [7:0] h, input int n,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] par,
                           input bit e0, input bit le, input bit e1,
                           input bit st);
        tbl[i].hdr = h;  tbl[i].n = n;
        tbl[i].p0 = a;   tbl[i].p1 = b;  tbl[i].p2 = c;
        tbl[i].par = par;
        tbl[i].e0 = e0;  tbl[i].le = le;
        tbl[i].e1 = e1;  tbl[i].stall = st;
    endtask

    // reference: parity and length check straight from the packet contents
    task automatic model(input logic [7:0] hdr, input int n,
                         input logic [7:0] par, output bit e0,
                         output bit le, output bit e1);
        logic [7:0] x, s;
        int cnt;
        x = hdr;
        s = hdr;
        for (int i = 0; i < n; i++) begin
            x = x ^ pl[i];
            s = s + pl[i];
        end
        cnt = (n > 63) ? 63 : n;
        e0 = (par != x);
        e1 = (par != s);
        le = (cnt != int'(hdr[7:2]));
    endtask

    initial begin
        bit e0, le, e1;
        logic [7:0] h, par;
        int n, k;

        set_vec(0, 8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, 0, 0, 1, 0);
        set_vec(1, 8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0E, 1, 0, 1, 0);
        set_vec(2, 8'h0D, 2, 8'h11, 8'h22, 8'h00, 8'h3E, 0, 1, 1, 0);
        set_vec(3, 8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h73, 1, 0, 0, 0);
        set_vec(4, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        set_vec(5, 8'h05, 0, 8'h00, 8'h00, 8'h00, 8'h05, 0, 1, 0, 0);
        set_vec(6, 8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D, 0, 0, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out0", {busy, dout_wr, dest_valid, parity_done, err,
                         len_err, dest, dout, err_count}, 32'd0);
        chk("rst_out1", {busy1, dout_wr1, dest_valid1, parity_done1, err1,
                         len_err1, dest1, dout1, err_count1}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            pl[0] = tbl[i].p0;
            pl[1] = tbl[i].p1;
            pl[2] = tbl[i].p2;
            send_pkt(tbl[i].hdr, tbl[i].n, tbl[i].par, tbl[i].e0,
                     tbl[i].le, tbl[i].e1, tbl[i].stall);
        end

        // abort while the queue holds bytes behind a full FIFO
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        ff_mode = 2;
        send_byte(1'b1, 8'h22);
        chk("abort_qfull", {31'h0, busy}, 32'd1);
        pkt_abort = 1'b1;
        pkt_valid = 1'b1;
        data_in = 8'h99;
        @(posedge clk);
        #1;
        pkt_abort = 1'b0;
        pkt_valid = 1'b0;
        sb.delete();
        ff_mode = 0;
        chk("abort_dout_wr", {31'h0, dout_wr}, 32'd0);
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_pdone", {31'h0, parity_done}, 32'd0);
        chk("abort_errcnt", {24'h0, err_count}, c0);
        chk("abort_dest", {30'h0, dest}, 32'd1);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_pkt(8'h0D, 3, 8'h0D, 0, 0, 1, 0);

        // payload counter saturates at 63, matching a length field of 63
        for (int i = 0; i < 70; i++) pl[i] = 8'($urandom);
        h = 8'hFF;
        model(h, 70, 8'h00, e0, le, e1);
        par = e0 ? 8'h00 : 8'h01;
        model(h, 70, par, e0, le, e1);
        send_pkt(h, 70, par, e0, le, e1, 0);

        ff_mode = 1;
        for (int t = 0; t < 40; t++) begin
            h = {3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
            n = ($urandom_range(0, 1) == 1) ? int'(h[7:2])
                                            : int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
            model(h, n, 8'h00, e0, le, e1);
            if ($urandom_range(0, 1) == 1) begin
                par = 8'h00;
                for (int i = 0; i < n; i++) par = par ^ pl[i];
                par = par ^ h;
            end else begin
                par = 8'($urandom);
            end
            model(h, n, par, e0, le, e1);
            send_pkt(h, n, par, e0, le, e1, 0);
        end
        ff_mode = 0;

        // drive err_count into saturation with length-error packets
        for (int t = 0; t < 260; t++) send_pkt(8'h05, 0, 8'h05, 0, 1, 0, 0);
        chk("errcnt_sat", {24'h0, err_count}, 32'd255);

        k = 0;
        while (dout_wr && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_dout_wr", {31'h0, dout_wr}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
